// File: rtl/rv_rsq_wr_pkg.sv
// rv_rsq_wr_pkg: shared rv issue-queue widths, legal depths and entry next-state ops.
package rv_rsq_wr_pkg;
  localparam int RV_ITAG_WIDTH = 7;
  localparam int RV_DAT_WIDTH = 7;
  localparam int RV_CNT_WIDTH = 5;
  typedef enum logic [1:0] {OP_HOLD, OP_SHIFT, OP_WRITE, OP_CLEAR} ent_op_e;
  function automatic logic q_entries_legal(int n);
    return n == 8 || n == 12 || n == 16;
  endfunction
endpackage

// File: rtl/rv_rsq_entry.sv
// rv_rsq_entry: one issue-queue slot with hold/shift/write/clear mux and wakeup compare.
module rv_rsq_entry
  import rv_rsq_wr_pkg::*;
#(
  parameter int dat_width_g = RV_DAT_WIDTH,
  parameter int itag_width_g = RV_ITAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  ent_op_e                 op,
  input  logic                    sh_val,
  input  logic                    sh_rdy,
  input  logic [itag_width_g-1:0] sh_itag,
  input  logic [dat_width_g-1:0]  sh_dat,
  input  logic                    wr_rdy,
  input  logic [itag_width_g-1:0] wr_itag,
  input  logic [dat_width_g-1:0]  wr_dat,
  input  logic                    wake_v,
  input  logic [itag_width_g-1:0] wake_itag,
  output logic                    val,
  output logic                    rdy,
  output logic [itag_width_g-1:0] itag,
  output logic [dat_width_g-1:0]  dat
);
  logic val_q, val_d, rdy_q, rdy_d;
  logic [itag_width_g-1:0] itag_q, itag_d;
  logic [dat_width_g-1:0] dat_q, dat_d;
  always_comb begin
    val_d  = op == OP_CLEAR ? 1'b0 : op == OP_WRITE ? 1'b1 : op == OP_SHIFT ? sh_val : val_q;
    itag_d = op == OP_WRITE ? wr_itag : op == OP_SHIFT ? sh_itag : itag_q;
    dat_d  = op == OP_WRITE ? wr_dat : op == OP_SHIFT ? sh_dat : dat_q;
    rdy_d  = op == OP_CLEAR ? 1'b0 : op == OP_WRITE ? wr_rdy : op == OP_SHIFT ? sh_rdy : rdy_q;
    // wakeup evaluated on the post-mux contents so it follows a shifting entry
    rdy_d  = rdy_d | (val_d & wake_v & (itag_d == wake_itag));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= 1'b0;
      rdy_q  <= 1'b0;
      itag_q <= '0;
      dat_q  <= '0;
    end else begin
      val_q  <= val_d;
      rdy_q  <= rdy_d;
      itag_q <= itag_d;
      dat_q  <= dat_d;
    end
  end
  assign val  = val_q;
  assign rdy  = rdy_q;
  assign itag = itag_q;
  assign dat  = dat_q;
endmodule

// File: rtl/rv_rsq_wr.sv
// rv_rsq_wr: age-ordered issue-queue write side, compacted toward the top index for the priority mux.
module rv_rsq_wr
  import rv_rsq_wr_pkg::*;
#(
  parameter int q_num_entries_g = 16,
  parameter int q_dat_width_g = RV_DAT_WIDTH,
  parameter int q_itag_width_g = RV_ITAG_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic                                      in_v,
  input  logic [q_dat_width_g-1:0]                  in_dat,
  input  logic                                      in_rdy,
  input  logic [q_itag_width_g-1:0]                 in_src_itag,
  output logic                                      in_full,
  input  logic                                      wake_v,
  input  logic [q_itag_width_g-1:0]                 wake_itag,
  output logic [0:q_num_entries_g-1]                cond,
  output logic [0:q_dat_width_g*q_num_entries_g-1]  din,
  input  logic                                      issue_take,
  output logic [RV_CNT_WIDTH-1:0]                   cnt
);
  localparam int N = q_num_entries_g;
  localparam logic [RV_CNT_WIDTH-1:0] N_C = RV_CNT_WIDTH'(N);
  logic [RV_CNT_WIDTH-1:0] cnt_q, cnt_d, base, wr_slot, sel;
  logic any, take, wr;
  logic [N-1:0] shift_en;
  ent_op_e op [N];
  logic val_w [N];
  logic rdy_w [N];
  logic [q_itag_width_g-1:0] itag_w [N];
  logic [q_dat_width_g-1:0] dat_w [N];
  logic sh_val [N];
  logic sh_rdy [N];
  logic [q_itag_width_g-1:0] sh_itag [N];
  logic [q_dat_width_g-1:0] sh_dat [N];
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) if (cond[i]) sel = RV_CNT_WIDTH'(i);
    any = |cond;
    take = issue_take & any;
    wr = in_v & ~in_full;
    base = N_C - cnt_q;
    // with a take the valid block slides up one, freeing slot base itself
    wr_slot = take ? base : base - 1'b1;
    cnt_d = flush ? '0 : cnt_q + RV_CNT_WIDTH'(wr) - RV_CNT_WIDTH'(take);
    for (int i = 0; i < N; i++) begin
      shift_en[i] = take & (RV_CNT_WIDTH'(i) <= sel) & (RV_CNT_WIDTH'(i) >= base);
      op[i] = flush ? OP_CLEAR : (wr && wr_slot == RV_CNT_WIDTH'(i)) ? OP_WRITE : shift_en[i] ? OP_SHIFT : OP_HOLD;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
  assign in_full = cnt_q == N_C;
  for (genvar g = 0; g < N; g++) begin : g_ent
    if (g == 0) begin : g_bot
      assign sh_val[g] = 1'b0;
      assign sh_rdy[g] = 1'b0;
      assign sh_itag[g] = '0;
      assign sh_dat[g] = '0;
    end else begin : g_up
      assign sh_val[g] = val_w[g-1];
      assign sh_rdy[g] = rdy_w[g-1];
      assign sh_itag[g] = itag_w[g-1];
      assign sh_dat[g] = dat_w[g-1];
    end
    rv_rsq_entry #(.dat_width_g(q_dat_width_g), .itag_width_g(q_itag_width_g)) u_ent (
      .clk(clk), .rst(rst), .op(op[g]),
      .sh_val(sh_val[g]), .sh_rdy(sh_rdy[g]), .sh_itag(sh_itag[g]), .sh_dat(sh_dat[g]),
      .wr_rdy(in_rdy), .wr_itag(in_src_itag), .wr_dat(in_dat),
      .wake_v(wake_v), .wake_itag(wake_itag),
      .val(val_w[g]), .rdy(rdy_w[g]), .itag(itag_w[g]), .dat(dat_w[g])
    );
    assign cond[g] = val_w[g] & rdy_w[g];
    assign din[g*q_dat_width_g +: q_dat_width_g] = dat_w[g];
  end
  a_depth: assert property (@(posedge clk) q_entries_legal(N))
    else $warning("rv_rsq_wr: unsupported queue depth %0d", N);
  a_take: assert property (@(posedge clk) disable iff (rst) !(issue_take && !any))
    else $warning("rv_rsq_wr: issue_take with no ready entry ignored");
  a_wr: assert property (@(posedge clk) disable iff (rst) !(in_v && in_full))
    else $warning("rv_rsq_wr: write dropped while queue full");
endmodule
